// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_kbd_pkg : shared PS/2 scan-code constants, receiver states, translation
// Revision    : 1.0
// ---------------------------------------------------------------------------
package ps2_kbd_pkg;

    localparam logic [7:0] C_PFX_EXT   = 8'hE0;
    localparam logic [7:0] C_PFX_BRK   = 8'hF0;
    localparam logic [7:0] C_PFX_PAUSE = 8'hE1;

    localparam logic [7:0] C_SHIFT_L   = 8'h12;
    localparam logic [7:0] C_SHIFT_R   = 8'h59;
    localparam logic [7:0] C_CTRL      = 8'h14;
    localparam logic [7:0] C_ALT       = 8'h11;
    localparam logic [7:0] C_CAPS      = 8'h58;

    // Bytes following E1 that belong to the pause sequence
    localparam logic [2:0] C_PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       valid;
        logic [6:0] code;
    } xlate_t;

    function automatic xlate_t xlate(input logic ext, input logic [7:0] b);
        xlate_t r;
        r = '0;
        if (ext) begin
            case (b)
                8'h75:   r = {1'b1, 7'h60};
                8'h72:   r = {1'b1, 7'h62};
                8'h6B:   r = {1'b1, 7'h63};
                8'h74:   r = {1'b1, 7'h64};
                8'h71:   r = {1'b1, 7'h65};
                8'h6C:   r = {1'b1, 7'h67};
                8'h69:   r = {1'b1, 7'h68};
                8'h5A:   r = {1'b1, 7'h5A};
                8'h4A:   r = {1'b1, 7'h4A};
                default: r = '0;
            endcase
        end else if (b == 8'h83) begin
            r = {1'b1, 7'h02};
        end else if (b != 8'h00 && !b[7]) begin
            r = {1'b1, b[6:0]};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_rx   : PS/2 line synchronizer, clock glitch filter and frame receiver
// Revision : 1.0
// ---------------------------------------------------------------------------
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q, filt_prev_q;
    logic          w_fall;
    logic          w_dat;

    rx_state_e     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q, frame_error_q;

    assign w_dat  = dat_sync_q[1];
    assign w_fall = filt_prev_q & ~filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_data};
            filt_prev_q <= filt_q;
            // Filtered level flips only after FILTER_LEN consecutive differing samples
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RX_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            tmr_q         <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (w_fall) begin
                tmr_q <= '0;
                case (state_q)
                    RX_IDLE: begin
                        if (!w_dat) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {w_dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q   <= w_dat;
                        state_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_q <= RX_IDLE;
                        if (w_dat && (^{shift_q, par_q})) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE) begin
                if (tmr_q == TW'(TIMEOUT - 1)) begin
                    state_q       <= RX_IDLE;
                    frame_error_q <= 1'b1;
                    tmr_q         <= '0;
                end else begin
                    tmr_q <= tmr_q + 1'b1;
                end
            end else begin
                tmr_q <= '0;
            end
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_error_o = frame_error_q;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder : PS/2 scan-code set 2 decoder with modifier tracking
// Revision             : 1.0
// ---------------------------------------------------------------------------
module ps2_keyboard_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       keypress,
    output logic [6:0] keycode,
    output logic [3:0] shift_state,
    output logic       frame_error
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    xlate_t     w_x;

    logic       ext_q, brk_q;
    logic [2:0] skip_q;
    logic       shift_l_q, shift_r_q, ctrl_l_q, ctrl_r_q, alt_l_q, alt_r_q;
    logic       caps_q, held_q;
    logic       keypress_q;
    logic [6:0] keycode_q;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .byte_o        (w_rx_byte),
        .byte_valid_o  (w_rx_valid),
        .frame_error_o (frame_error)
    );

    assign w_x = xlate(ext_q, w_rx_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            ctrl_l_q   <= 1'b0;
            ctrl_r_q   <= 1'b0;
            alt_l_q    <= 1'b0;
            alt_r_q    <= 1'b0;
            caps_q     <= 1'b0;
            held_q     <= 1'b0;
            keypress_q <= 1'b0;
            keycode_q  <= '0;
        end else begin
            keypress_q <= 1'b0;
            if (w_rx_valid) begin
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 1'b1;
                end else if (w_rx_byte == C_PFX_PAUSE) begin
                    skip_q <= C_PAUSE_SKIP;
                    ext_q  <= 1'b0;
                    brk_q  <= 1'b0;
                end else if (w_rx_byte == C_PFX_EXT) begin
                    ext_q <= 1'b1;
                end else if (w_rx_byte == C_PFX_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (!ext_q && w_rx_byte == C_SHIFT_L) begin
                        shift_l_q <= ~brk_q;
                    end else if (!ext_q && w_rx_byte == C_SHIFT_R) begin
                        shift_r_q <= ~brk_q;
                    end else if (w_rx_byte == C_CTRL) begin
                        if (ext_q) ctrl_r_q <= ~brk_q;
                        else       ctrl_l_q <= ~brk_q;
                    end else if (w_rx_byte == C_ALT) begin
                        if (ext_q) alt_r_q <= ~brk_q;
                        else       alt_l_q <= ~brk_q;
                    end else if (!ext_q && w_rx_byte == C_CAPS) begin
                        // Held flag keeps typematic repeats from re-toggling caps
                        if (brk_q) begin
                            held_q <= 1'b0;
                        end else if (!held_q) begin
                            caps_q <= ~caps_q;
                            held_q <= 1'b1;
                        end
                    end else if (!brk_q && w_x.valid) begin
                        keypress_q <= 1'b1;
                        keycode_q  <= w_x.code;
                    end
                end
            end
        end
    end

    assign keypress    = keypress_q;
    assign keycode     = keycode_q;
    assign shift_state = {caps_q, alt_l_q | alt_r_q, ctrl_l_q | ctrl_r_q, shift_l_q | shift_r_q};

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_decoder : directed PS/2 frames with a queue-based scoreboard
// Revision                : 1.0
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 20;

    typedef struct {
        bit         is_err;
        logic [6:0] code;
        logic [3:0] sh;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keypress;
    logic [6:0] keycode;
    logic [3:0] shift_state;
    logic       frame_error;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat   = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    ps2_keyboard_decoder #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keypress    (keypress),
        .keycode     (keycode),
        .shift_state (shift_state),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && (keypress || frame_error)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: keypress=%0b frame_error=%0b keycode=%h, required no strobe",
                         keypress, frame_error, keycode);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err) begin
                    if (!frame_error || keypress) begin
                        n_bad++;
                        $display("FAIL frame_error_event: keypress=%0b frame_error=%0b, required frame_error only",
                                 keypress, frame_error);
                    end
                end else if (!keypress || frame_error || keycode !== mon_e.code || shift_state !== mon_e.sh) begin
                    n_bad++;
                    $display("FAIL key_event: keypress=%0b err=%0b keycode=%h shift=%b, required keycode=%h shift=%b",
                             keypress, frame_error, keycode, shift_state, mon_e.code, mon_e.sh);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_key(input logic [6:0] code, input logic [3:0] sh);
        ev_t e;
        e.is_err = 1'b0;
        e.code   = code;
        e.sh     = sh;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.code   = '0;
        e.sh     = '0;
        exp_q.push_back(e);
    endtask

    // Frame bits LSB first: start, 8 data, parity, stop
    task automatic send_bits(input logic [7:0] b, input bit good_par, input int nbits, input bit meas);
        logic [10:0] fr;
        fr = {1'b1, (good_par ? ~(^b) : (^b)), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(HALF);
            ps2_clk = 1'b0;
            for (int c = 0; c < HALF; c++) begin
                @(posedge clk);
                #1;
                if (meas && i == 10 && keypress && lat == 0) lat = c + 1;
            end
            @(negedge clk);
            ps2_clk = 1'b1;
        end
        if (nbits == 11) tick(2 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b1, 11, 1'b0);
    endtask

    initial begin
        tick(4);
        chk("reset_keypress", 32'(keypress), 32'h0);
        chk("reset_keycode", 32'(keycode), 32'h0);
        chk("reset_shift", 32'(shift_state), 32'h0);
        chk("reset_frame_error", 32'(frame_error), 32'h0);
        reset = 1'b0;
        tick(50);

        // Plain make code with latency measurement from the raw stop-bit fall
        push_key(7'h1C, 4'b0000);
        send_bits(8'h1C, 1'b1, 11, 1'b1);
        chk("stop_to_keypress_latency", 32'(lat), 32'(FILTER_LEN + 4));

        // Shifted key, then release everything
        send(8'h12);
        chk("shift_after_make", 32'(shift_state), 32'h1);
        push_key(7'h1C, 4'b0001);
        send(8'h1C);
        send(8'hF0); send(8'h1C);
        chk("shift_after_key_break", 32'(shift_state), 32'h1);
        send(8'hF0); send(8'h12);
        chk("shift_after_release", 32'(shift_state), 32'h0);

        // Extended codes and pause sequence
        push_key(7'h60, 4'b0000);
        send(8'hE0); send(8'h75);
        chk("keycode_ext_75", 32'(keycode), 32'h60);
        send(8'hE0); send(8'h7C);
        send(8'hE0); send(8'h14);
        chk("ctrl_r_make", 32'(shift_state), 32'h2);
        send(8'hE0); send(8'hF0); send(8'h14);
        chk("ctrl_r_break", 32'(shift_state), 32'h0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_no_ctrl", 32'(shift_state), 32'h0);
        push_key(7'h1C, 4'b0000);
        send(8'h1C);
        push_key(7'h02, 4'b0000);
        send(8'h83);
        send(8'h00);
        send(8'h84);

        // Caps lock with typematic repeat
        send(8'h58);
        chk("caps_first_make", 32'(shift_state[3]), 32'h1);
        send(8'h58);
        chk("caps_repeat", 32'(shift_state[3]), 32'h1);
        send(8'hF0); send(8'h58);
        send(8'h58);
        chk("caps_third_make", 32'(shift_state[3]), 32'h0);
        send(8'hF0); send(8'h58);
        chk("caps_final", 32'(shift_state), 32'h0);

        // Parity error, timeout, then recovery
        push_err();
        send_bits(8'h1C, 1'b0, 11, 1'b0);
        push_err();
        send_bits(8'h1C, 1'b1, 4, 1'b0);
        tick(TIMEOUT + 40);
        push_key(7'h1C, 4'b0000);
        send(8'h1C);

        // Short low glitch on ps2_clk with data low must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(50);
        push_key(7'h2A, 4'b0000);
        send(8'h2A);
        chk("keycode_after_glitch", 32'(keycode), 32'h2A);

        // Reset in the middle of a frame while shift is held
        send(8'h12);
        send_bits(8'h1C, 1'b1, 5, 1'b0);
        reset = 1'b1;
        tick(3);
        chk("midreset_keypress", 32'(keypress), 32'h0);
        chk("midreset_keycode", 32'(keycode), 32'h0);
        chk("midreset_shift", 32'(shift_state), 32'h0);
        chk("midreset_frame_error", 32'(frame_error), 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b0;
        tick(50);
        push_key(7'h1C, 4'b0000);
        send(8'h1C);
        tick(20);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
